// File: rtl/tdm_pkg.sv
// tdm_pkg: definitions shared by the TDM multiplexer/demultiplexer pair.
//   LANES          number of lanes carried per frame
//   DEFAULT_WIDTH  default symbol/lane width in bits
//   LANE_A..LANE_D lane encodings, identical to the multiplexer SEL encoding
//   ERR_CNT_W      width of the optional abort counter
//   next_lane()    lane index that follows a given lane, wrapping D -> A
package tdm_pkg;

  localparam int LANES         = 4;
  localparam int DEFAULT_WIDTH = 2;
  localparam int ERR_CNT_W     = 8;

  localparam logic [1:0] LANE_A = 2'b00;
  localparam logic [1:0] LANE_B = 2'b01;
  localparam logic [1:0] LANE_C = 2'b10;
  localparam logic [1:0] LANE_D = 2'b11;

  function automatic logic [1:0] next_lane(input logic [1:0] lane);
    return lane + 2'd1;
  endfunction

endpackage

// File: rtl/tdm_lane_counter.sv
// tdm_lane_counter: tracks which lane the next accepted beat belongs to.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   beat        a symbol is accepted this cycle
//   sof         start of frame; only meaningful when beat=1
//   sel         lane index of the next expected beat (the counter state)
//   wrap        strobe: this beat completes a frame (lane D, no SOF)
//   abort       strobe: this SOF beat discards a partial frame
// wrap and abort are combinational and are registered by the parent.
module tdm_lane_counter
  import tdm_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       beat,
  input  logic       sof,
  output logic [1:0] sel,
  output logic       wrap,
  output logic       abort
);

  logic [1:0] sel_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel <= LANE_A;
    end else begin
      sel <= sel_next;
    end
  end

  // A SOF beat is lane A, so the next expected lane is B. An SOF arriving
  // anywhere other than lane A, including lane D, restarts the frame and
  // never completes it.
  always_comb begin
    sel_next = sel;
    wrap     = 1'b0;
    abort    = 1'b0;
    if (beat) begin
      if (sof) begin
        sel_next = LANE_B;
        abort    = (sel != LANE_A);
      end else begin
        sel_next = next_lane(sel);
        wrap     = (sel == LANE_D);
      end
    end
  end

endmodule

// File: rtl/tdm_demultiplexer.sv
// tdm_demultiplexer: rebuilds four parallel lanes from a TDM symbol stream.
// Beats arrive in lane order A, B, C, D; A..C are staged and the frame is
// published on the lane-D beat together with a one-cycle frame_valid.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   x_in [WIDTH]        incoming symbol
//   x_valid             x_in holds a beat this cycle (always accepted)
//   sof                 beat is lane A (sampled only with x_valid)
//   a, b, c, d [WIDTH]  registered lanes, updated only on frame completion
//   frame_valid         one-cycle pulse, a..d just updated
//   sel [2]             lane index of the next expected beat
//   err                 one-cycle pulse, a partial frame was aborted
//   err_cnt [8]         saturating abort count (only with TDM_DEMUX_ERRCNT_EN)
// Build option: define TDM_DEMUX_ERRCNT_EN to add err_cnt.
module tdm_demultiplexer
  import tdm_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] x_in,
  input  logic             x_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             frame_valid,
  output logic [1:0]       sel,
  output logic             err
`ifdef TDM_DEMUX_ERRCNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  logic [WIDTH-1:0] sa, sb, sc;
  logic             wrap, abort;

  tdm_lane_counter u_lane_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .beat  (x_valid),
    .sof   (sof),
    .sel   (sel),
    .wrap  (wrap),
    .abort (abort)
  );

  // wrap and abort are mutually exclusive (sof selects one or the other),
  // so frame_valid and err can never be high together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa          <= '0;
      sb          <= '0;
      sc          <= '0;
      a           <= '0;
      b           <= '0;
      c           <= '0;
      d           <= '0;
      frame_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      frame_valid <= wrap;
      err         <= abort;
      if (x_valid) begin
        if (sof) begin
          // Stale sb/sc are left in place; the restarted frame overwrites
          // them before they can be published.
          sa <= x_in;
        end else begin
          unique case (sel)
            LANE_A: sa <= x_in;
            LANE_B: sb <= x_in;
            LANE_C: sc <= x_in;
            LANE_D: begin
              a <= sa;
              b <= sb;
              c <= sc;
              d <= x_in;
            end
          endcase
        end
      end
    end
  end

`ifdef TDM_DEMUX_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (abort && (err_cnt != {ERR_CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_tdm_demultiplexer.sv
// tb_tdm_demultiplexer: table-driven bench for tdm_demultiplexer (WIDTH=2).
// Each table row is one cycle of stimulus with the expected sel, pulses and,
// for completing beats, the expected {a,b,c,d} frame. Expected frames are
// queued when the completing beat is driven and popped by a monitor that
// watches frame_valid.
module tb_tdm_demultiplexer;
  import tdm_pkg::*;

  localparam int W = 2;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] x_in;
  logic         x_valid;
  logic         sof;
  logic [W-1:0] a, b, c, d;
  logic         frame_valid;
  logic [1:0]   sel;
  logic         err;
`ifdef TDM_DEMUX_ERRCNT_EN
  logic [7:0]   err_cnt;
`endif

  tdm_demultiplexer #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .x_in        (x_in),
    .x_valid     (x_valid),
    .sof         (sof),
    .a           (a),
    .b           (b),
    .c           (c),
    .d           (d),
    .frame_valid (frame_valid),
    .sel         (sel),
    .err         (err)
`ifdef TDM_DEMUX_ERRCNT_EN
    ,
    .err_cnt     (err_cnt)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic         v;
    logic         s;
    logic [W-1:0] x;
    logic [1:0]   esel;
    logic         efv;
    logic         eerr;
    logic [7:0]   frame;   // {a,b,c,d} expected when efv=1
  } vec_t;

  logic [7:0] exp_q[$];
  vec_t       tbl[$];
  logic [7:0] last_frame;
  int         exp_errs;
  int         checks;
  int         errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic s, input logic [W-1:0] x,
                              input logic [1:0] esel, input logic efv, input logic eerr,
                              input logic [7:0] frame);
    vec_t t;
    t.v = v; t.s = s; t.x = x; t.esel = esel; t.efv = efv; t.eerr = eerr; t.frame = frame;
    return t;
  endfunction

  // ---------------- driver ----------------
  task automatic apply(input vec_t t);
    @(negedge clk);
    x_valid = t.v;
    sof     = t.s;
    x_in    = t.x;
    if (t.efv) exp_q.push_back(t.frame);
    if (t.eerr && exp_errs < 255) exp_errs++;
    @(posedge clk);
    #1;
    check("sel", {30'd0, sel}, {30'd0, t.esel});
    check("frame_valid", {31'd0, frame_valid}, {31'd0, t.efv});
    check("err", {31'd0, err}, {31'd0, t.eerr});
    if (t.efv) last_frame = t.frame;
    check("lanes", {24'd0, a, b, c, d}, {24'd0, last_frame});
`ifdef TDM_DEMUX_ERRCNT_EN
    check("err_cnt", {24'd0, err_cnt}, exp_errs);
`endif
  endtask

  task automatic run_table();
    foreach (tbl[i]) apply(tbl[i]);
    tbl.delete();
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n && frame_valid) begin
      check("fv_err_exclusive", {31'd0, err}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_frame", 32'd1, 32'd0);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("sb_frame", {24'd0, a, b, c, d}, {24'd0, e});
      end
    end
  end

  // ---------------- test ----------------
  initial begin
    logic [W-1:0] lanes [4];
    checks = 0; errors = 0; exp_errs = 0; last_frame = 8'h00;
    rst_n = 1'b0; x_valid = 1'b0; sof = 1'b0; x_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_lanes", {24'd0, a, b, c, d}, 32'd0);
    check("rst_sel", {30'd0, sel}, 32'd0);
    check("rst_fv", {31'd0, frame_valid}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
`ifdef TDM_DEMUX_ERRCNT_EN
    check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Gapped frame first, so the held outputs must still read 0 in the gaps.
    // Gap rows carry sof=1 to show it is ignored without x_valid.
    tbl.push_back(mk(1, 1, 2'b10, 2'd1, 0, 0, 8'h00));
    tbl.push_back(mk(0, 1, 2'b11, 2'd1, 0, 0, 8'h00));
    tbl.push_back(mk(0, 0, 2'b00, 2'd1, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 2'b01, 2'd2, 0, 0, 8'h00));
    tbl.push_back(mk(0, 1, 2'b10, 2'd2, 0, 0, 8'h00));
    tbl.push_back(mk(0, 1, 2'b11, 2'd2, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 2'b00, 2'd3, 0, 0, 8'h00));
    tbl.push_back(mk(0, 0, 2'b01, 2'd3, 0, 0, 8'h00));
    tbl.push_back(mk(0, 1, 2'b01, 2'd3, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 2'b11, 2'd0, 1, 0, 8'b10_01_00_11));
    // Aligned frame with a different pattern so an update is visible.
    tbl.push_back(mk(1, 1, 2'b01, 2'd1, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 2'b11, 2'd2, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 2'b10, 2'd3, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 2'b00, 2'd0, 1, 0, 8'b01_11_10_00));
    // Aligned frame from the test plan.
    tbl.push_back(mk(1, 1, 2'b10, 2'd1, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 2'b01, 2'd2, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 2'b00, 2'd3, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 2'b11, 2'd0, 1, 0, 8'b10_01_00_11));
    // Abort at lane C, then a completed restarted frame.
    tbl.push_back(mk(1, 1, 2'b11, 2'd1, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 2'b10, 2'd2, 0, 0, 8'h00));
    tbl.push_back(mk(1, 1, 2'b01, 2'd1, 0, 1, 8'h00));
    tbl.push_back(mk(1, 0, 2'b10, 2'd2, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 2'b00, 2'd3, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 2'b11, 2'd0, 1, 0, 8'b01_10_00_11));
    // Free-running alignment: no SOF at all.
    tbl.push_back(mk(1, 0, 2'b01, 2'd1, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 2'b10, 2'd2, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 2'b11, 2'd3, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 2'b00, 2'd0, 1, 0, 8'b01_10_11_00));
    // SOF on the lane-D slot: abort and restart, not a completion.
    tbl.push_back(mk(1, 1, 2'b00, 2'd1, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 2'b00, 2'd2, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 2'b00, 2'd3, 0, 0, 8'h00));
    tbl.push_back(mk(1, 1, 2'b11, 2'd1, 0, 1, 8'h00));
    tbl.push_back(mk(1, 0, 2'b01, 2'd2, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 2'b10, 2'd3, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 2'b00, 2'd0, 1, 0, 8'b11_01_10_00));
    run_table();

    // Round trip: a multiplexer sweeping its SEL every cycle, valid held high.
    // First frame uses the test-plan lanes, the rest are random.
    for (int f = 0; f < 4; f++) begin
      if (f == 0) begin
        lanes[0] = 2'b10; lanes[1] = 2'b01; lanes[2] = 2'b00; lanes[3] = 2'b11;
      end else begin
        for (int k = 0; k < 4; k++) lanes[k] = W'($urandom_range(0, 3));
      end
      for (int k = 0; k < 4; k++) begin
        apply(mk(1, 0, lanes[k], 2'((k + 1) % 4), (k == 3), 0,
                 {lanes[0], lanes[1], lanes[2], lanes[3]}));
      end
    end

`ifdef TDM_DEMUX_ERRCNT_EN
    // Drive the abort counter past saturation, then realign at lane A.
    apply(mk(1, 0, 2'b00, 2'd1, 0, 0, 8'h00));
    for (int i = 0; i < 260; i++) apply(mk(1, 1, 2'b00, 2'd1, 0, 1, 8'h00));
    apply(mk(1, 0, 2'b00, 2'd2, 0, 0, 8'h00));
    apply(mk(1, 0, 2'b00, 2'd3, 0, 0, 8'h00));
    apply(mk(1, 0, 2'b00, 2'd0, 1, 0, 8'h00));
`endif

    // Reset in the middle of a frame.
    apply(mk(1, 1, 2'b01, 2'd1, 0, 0, 8'h00));
    apply(mk(1, 0, 2'b10, 2'd2, 0, 0, 8'h00));
    @(negedge clk);
    rst_n = 1'b0; x_valid = 1'b0; sof = 1'b0;
    #1;
    check("midrst_lanes", {24'd0, a, b, c, d}, 32'd0);
    check("midrst_sel", {30'd0, sel}, 32'd0);
    last_frame = 8'h00;
    exp_errs   = 0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("midrst_fv", {31'd0, frame_valid}, 32'd0);
      check("midrst_err", {31'd0, err}, 32'd0);
`ifdef TDM_DEMUX_ERRCNT_EN
      check("midrst_err_cnt", {24'd0, err_cnt}, 32'd0);
`endif
    end
    @(negedge clk);
    rst_n = 1'b1;
    tbl.push_back(mk(1, 1, 2'b11, 2'd1, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 2'b11, 2'd2, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 2'b11, 2'd3, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 2'b11, 2'd0, 1, 0, 8'hFF));
    tbl.push_back(mk(0, 0, 2'b00, 2'd0, 0, 0, 8'h00));
    tbl.push_back(mk(0, 0, 2'b00, 2'd0, 0, 0, 8'h00));
    run_table();

    @(negedge clk);
    check("pending_frames", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
